// File: rtl/connector_pkg.sv
// connector_pkg: shared constants, output-stage state and index-width helper for the connector hub.
package connector_pkg;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_DATA_W    = 8;

    typedef enum logic {EMPTY, FULL} stage_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/connector_rr_arb.sv
// connector_rr_arb: round-robin arbiter searching upward from ptr with wrap-around.
module connector_rr_arb
    import connector_pkg::*;
#(
    parameter int N = DEF_NUM_PORTS,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] gidx,
    output logic         any_grant
);

    logic [2*N-1:0] dbl;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotating a doubled copy puts the search start at bit 0.
    always_comb begin
        dbl       = {req, req} >> ptr;
        off       = '0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                off       = W'(k);
                any_grant = 1'b1;
            end
        end
        sum   = {1'b0, ptr} + {1'b0, off};
        gidx  = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : W'(sum);
        grant = any_grant ? (N'(1) << gidx) : '0;
    end

endmodule

// File: rtl/connector_pn_hub.sv
// connector_pn_hub: per-channel one-entry buffers merged round-robin into a registered output stage.
module connector_pn_hub
    import connector_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int DATA_W    = DEF_DATA_W,
    localparam int IDX_W    = idx_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic [NUM_PORTS-1:0]        in_ready,
    input  logic                        freeze,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_port,
    input  logic                        out_ready,
    output logic [NUM_PORTS-1:0]        valid0
);

    stage_t                 state, state_nx;
    logic [NUM_PORTS-1:0]   pending;
    logic [NUM_PORTS-1:0]   capture;
    logic [NUM_PORTS-1:0]   grant;
    logic [DATA_W-1:0]      slot [NUM_PORTS];
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gidx;
    logic                   any_grant;
    logic                   load;

    // Ready depends only on registered pending and freeze, never on out_ready.
    assign in_ready  = {NUM_PORTS{~freeze}} & (rst ? '1 : ~pending);
    assign capture   = in_valid & in_ready;
    assign out_valid = (state == FULL);
    assign valid0    = pending;

    connector_rr_arb #(.N(NUM_PORTS), .W(IDX_W)) u_arb (
        .req       (pending),
        .ptr       (ptr),
        .grant     (grant),
        .gidx      (gidx),
        .any_grant (any_grant)
    );

    always_comb begin
        load     = !freeze && any_grant && (state == EMPTY || out_ready);
        state_nx = load ? FULL : (state == FULL && out_ready) ? EMPTY : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            pending  <= '0;
            out_data <= '0;
            out_port <= '0;
            ptr      <= '0;
        end else begin
            state   <= state_nx;
            pending <= (pending & ~(grant & {NUM_PORTS{load}})) | capture;
            if (load) begin
                out_data <= slot[gidx];
                out_port <= gidx;
                ptr      <= (gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++)
            if (capture[i]) slot[i] <= in_data[i*DATA_W +: DATA_W];
    end

endmodule

// File: doc/connector_pn_hub.md
CONNECTOR_PN_HUB -- requirements
Module: connector_pn_hub

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 8: data width per channel, legal range 1..64.
REQ-003 SHALL have derived parameter IDX_W = max(1, clog2(NUM_PORTS)): port-index width.
REQ-004 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-005 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: in_valid  in  NUM_PORTS  per-channel valid.
REQ-008 Port: in_data  in  NUM_PORTS*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port: in_ready  out  NUM_PORTS  per-channel ready.
REQ-010 Port: freeze  in  1  when high, halts capture and arbitration.
REQ-011 Port: out_valid  out  1  output word valid.
REQ-012 Port: out_data  out  DATA_W  output word.
REQ-013 Port: out_port  out  IDX_W  source channel of out_data.
REQ-014 Port: out_ready  in  1  downstream accept.
REQ-015 Port: valid0  out  NUM_PORTS  per-channel pending-word status.

Function
REQ-016 Each channel SHALL hold a one-entry buffer with a pending flag; valid0[i] SHALL equal pending[i].
REQ-017 in_ready[i] SHALL be !pending[i] && !freeze, with no combinational path from out_ready.
REQ-018 A capture on channel i SHALL occur when in_valid[i] && in_ready[i] at a clock edge: data stored, pending[i] set.
REQ-019 The output stage SHALL be a registered two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 A load SHALL occur when freeze=0, any pending bit is set, and the stage is EMPTY or out_ready=1.
REQ-021 On a load, the granted channel's word and index SHALL appear on out_data/out_port; its pending bit SHALL clear; the stage SHALL be FULL.
REQ-022 In FULL with out_ready=1 and no load, the stage SHALL go to EMPTY.
REQ-023 In FULL with out_ready=0, out_valid, out_data and out_port SHALL hold stable.
REQ-024 Arbitration SHALL be round-robin: search from pointer ptr upward with wrap-around; after a grant to g, ptr SHALL become (g+1) mod NUM_PORTS.
REQ-025 Latency SHALL be one cycle: a word captured at edge k is on the output after edge k+1 if granted and not blocked.
REQ-026 Sustained throughput SHALL be one word per cycle in aggregate while out_ready=1 and words are pending.
REQ-027 A channel SHALL raise in_ready the cycle after its grant, so it accepts a new word one cycle later; capture and grant on the same channel in the same edge SHALL NOT occur.
REQ-028 With freeze=1 there SHALL be no captures and no loads, and ptr SHALL hold; an already-FULL output SHALL still complete on out_ready=1 and go EMPTY.
REQ-029 Freeze deassertion SHALL resume arbitration on the next edge without losing any pending word.
REQ-030 No word SHALL be dropped or duplicated under any in_valid/out_ready/freeze sequence.

Reset
REQ-031 While rst=1 at an edge, pending, out_valid, out_data, out_port and ptr SHALL all clear to 0.
REQ-032 During reset, in_ready SHALL be 0 only if freeze=1; valid0 SHALL be 0.
REQ-033 Reset mid-transfer SHALL discard all buffered and output words; the first grant after reset SHALL favour channel 0.
REQ-034 rst SHALL take priority over freeze, capture and load in the same cycle.

Structure
REQ-035 Package connector_pkg SHALL hold the default NUM_PORTS and DATA_W constants, the output-stage state enum (EMPTY, FULL), and an index-width helper function.
REQ-036 The round-robin arbiter SHALL be a sub-module connector_rr_arb, taking the request vector and ptr and producing a one-hot grant, a grant index and an any-grant flag.

Verification
REQ-037 Single word: after reset, channel 1 presents 0xA5 with out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_port=1, valid0=000.
REQ-038 Fairness: all 3 channels valid continuously, out_ready=1 -> out_port sequence 0,1,2,0,1,2 with no gaps.
REQ-039 Backpressure: out_ready=0 for 5 cycles with all channels loaded -> output stable, valid0=110 (3-bit vector written channel 2 down to channel 0), in_ready=001; release -> words 0x10, 0x11, 0x12 drain in order 0,1,2.
REQ-040 Freeze: freeze=1 while channel 2 is pending and the output is FULL, then out_ready=1 -> output drains, no new load, ptr unchanged; on freeze=0, channel 2 is granted next cycle.
REQ-041 Reset mid-operation: rst pulsed with valid0=111 and out_valid=1 -> all outputs 0 next cycle; subsequent simultaneous requests grant channel 0 first.
REQ-042 Parameter sweep: NUM_PORTS=5, DATA_W=32, random traffic for 10k cycles -> scoreboard confirms no loss or duplication and a maximum wait of at most NUM_PORTS grants per word.
